// File: rtl/rv_pkg.sv
// Shared RISC-V core definitions.
// Widths, reset vector and fetch bundle types.
package rv_pkg;

  localparam int XLEN           = 32;
  localparam int RV_INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RV_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] RV_NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/rv_fetch_fifo.sv
// Fetch buffer: small synchronous FIFO of {pc, word}.
// Flush wins over push; storage is cleared on reset so the head reads 0.
module rv_fetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 din,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output fetch_entry_t                 head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  cnt;
  logic           pop_ok;

  assign pop_ok = pop && (cnt != '0);
  assign count  = cnt;
  assign head   = mem[rd_ptr];

  // Pointer, occupancy and storage update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rv_fetch.sv
// Instruction fetch front end.
// Issues word PCs to a 1-cycle memory and buffers words for decode.
module rv_fetch
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RV_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        mclk,
  input  logic        rst,
  output logic [31:0] memPC,
  input  logic [31:0] memData,
  output logic        mem_req,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int UW = CW + 1;

  logic [XLEN-1:0] pc_q;
  logic            infl_q;
  logic [XLEN-1:0] infl_pc_q;
  logic [CW-1:0]   count;
  logic [UW-1:0]   used;
  logic            deq;
  logic            push;
  fetch_entry_t    head;
  fetch_entry_t    din;

  assign deq  = instr_valid && instr_ready;
  assign used = UW'(count) + UW'(infl_q) - UW'(deq);
  assign push = infl_q && !redirect_valid;
  assign din  = '{pc: infl_pc_q, word: memData};

  assign mem_req     = !rst && !redirect_valid && (used < UW'(DEPTH));
  assign memPC       = pc_q;
  assign instr_valid = (count != '0);
  assign instr       = head.word;
  assign instr_pc    = head.pc;

  // PC and in-flight tracking; redirect beats issue.
  always_ff @(posedge mclk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
    end else if (redirect_valid) begin
      pc_q   <= redirect_pc & 32'hFFFF_FFFC;
      infl_q <= 1'b0;
    end else if (mem_req) begin
      pc_q      <= pc_q + XLEN'(RV_INSTR_BYTES);
      infl_q    <= 1'b1;
      infl_pc_q <= pc_q;
    end else begin
      infl_q <= 1'b0;
    end
  end

  rv_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (mclk),
    .rst   (rst),
    .push  (push),
    .pop   (deq),
    .flush (redirect_valid),
    .din   (din),
    .count (count),
    .head  (head)
  );

endmodule

// File: tb/tb_rv_fetch.sv
// Bench for rv_fetch: transaction-history reference model.
// Directed scenarios followed by randomized ready/redirect/reset.
module tb_rv_fetch;
  import rv_pkg::*;

  localparam int          DEPTH   = 2;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_b;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_ready;

  logic [31:0] mem_pc;
  logic [31:0] mem_data;
  logic        mem_req;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  logic [31:0] mem_pc_b;
  logic [31:0] mem_data_b;
  logic        mem_req_b;
  logic        valid_b;
  logic [31:0] instr_b;
  logic [31:0] ipc_b;

  int total = 0;
  int bad = 0;

  req_t        q[$];
  logic [31:0] fpc;
  int          cyc;
  int          delivered;
  bit          after_rst;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  always @(posedge clk) mem_data <= word_at(mem_pc);
  always @(posedge clk) mem_data_b <= word_at(mem_pc_b);

  rv_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (DEPTH)
  ) dut (
    .mclk           (clk),
    .rst            (rst),
    .memPC          (mem_pc),
    .memData        (mem_data),
    .mem_req        (mem_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  rv_fetch #(
    .RESET_PC (WRAP_PC),
    .DEPTH    (DEPTH)
  ) dut_wrap (
    .mclk           (clk),
    .rst            (rst_b),
    .memPC          (mem_pc_b),
    .memData        (mem_data_b),
    .mem_req        (mem_req_b),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .instr_valid    (valid_b),
    .instr_ready    (1'b1),
    .instr          (instr_b),
    .instr_pc       (ipc_b)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // One cycle: compare DUT against the model at negedge, advance model.
  task automatic step();
    bit ev;
    bit deq;
    bit er;
    @(negedge clk);
    if (rst) begin
      check("req_in_rst", {31'b0, mem_req}, 32'd0);
      q.delete();
      fpc       = 32'h0;
      after_rst = 1'b1;
    end else begin
      ev = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
      if (after_rst) begin
        check("rst_instr", instr, 32'h0);
        check("rst_ipc", instr_pc, 32'h0);
        after_rst = 1'b0;
      end
      check("valid", {31'b0, instr_valid}, {31'b0, ev});
      if (ev) begin
        check("ipc", instr_pc, q[0].pc);
        check("iword", instr, word_at(q[0].pc));
      end
      deq = ev && instr_ready;
      er  = !redirect_valid && ((q.size() - int'(deq)) < DEPTH);
      check("mem_req", {31'b0, mem_req}, {31'b0, er});
      check("mem_pc", mem_pc, fpc);
      if (deq) begin
        void'(q.pop_front());
        delivered++;
      end
      if (redirect_valid) begin
        q.delete();
        fpc = redirect_pc & 32'hFFFF_FFFC;
      end else if (er) begin
        q.push_back('{cyc: cyc, pc: fpc});
        fpc = fpc + 32'd4;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r;
    int n;
    logic [31:0] wexp [4];
    rst            = 1'b1;
    rst_b          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b1;
    fpc            = 32'h0;
    cyc            = 0;
    delivered      = 0;
    after_rst      = 1'b0;
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;

    // stream, then backpressure after the 3rd instruction
    for (int i = 0; i < 20 && delivered < 3; i++) step();
    check("stream3", delivered, 3);
    instr_ready = 1'b0;
    repeat (5) step();
    check("stall_pc", mem_pc, 32'h14);
    instr_ready = 1'b1;

    // redirect while fetching 0x20
    for (int i = 0; i < 40 && mem_pc != 32'h20; i++) step();
    check("reach20", mem_pc, 32'h20);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    r = cyc;
    step();
    redirect_valid = 1'b0;
    check("redir_pc", mem_pc, 32'h100);
    for (int i = 0; i < 10 && !instr_valid; i++) step();
    check("redir_lat", cyc - r, 3);
    check("redir_ipc", instr_pc, 32'h100);
    check("redir_word", instr, word_at(32'h100));
    repeat (4) step();

    // redirect with a full buffer and decoder stalled
    instr_ready = 1'b0;
    repeat (4) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    step();
    redirect_valid = 1'b0;
    check("flush_empty", {31'b0, instr_valid}, 32'd0);
    step();
    instr_ready = 1'b1;
    repeat (6) step();

    // reset mid-stream with buffered entries
    instr_ready = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_valid", {31'b0, instr_valid}, 32'd0);
    check("mrst_pc", mem_pc, 32'h0);
    instr_ready = 1'b1;
    repeat (6) step();

    // randomized ready / redirect / reset
    for (int i = 0; i < 400; i++) begin
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom & 32'h0000_0FFF;
      rst            = ($urandom_range(0, 63) == 0);
      step();
    end
    rst            = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    repeat (4) step();

    // PC wrap on the second instance
    wexp[0] = 32'hFFFF_FFF8;
    wexp[1] = 32'hFFFF_FFFC;
    wexp[2] = 32'h0000_0000;
    wexp[3] = 32'h0000_0004;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      @(negedge clk);
      if (valid_b) begin
        check("wrap_pc", ipc_b, wexp[n]);
        check("wrap_word", instr_b, word_at(wexp[n]));
        n++;
      end
    end
    check("wrap_cnt", n, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
